// File: rtl/ct_merge_arb.sv
// Round-robin merge arbiter: NI flow-tagged ready/valid streams share one output.
// The grant is held from a packet's first beat through its eop beat; the datapath is purely combinational.
module ct_merge_arb #(
    parameter int NI = 2,
    parameter int WO = 8,
    parameter int WF = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NI*WO-1:0] i_data,
    input  logic [NI-1:0]    i_valid,
    input  logic [NI-1:0]    i_eop,
    input  logic [NI*WF-1:0] i_flow,
    output logic [NI-1:0]    o_ready,
    output logic [WO-1:0]    o_data,
    output logic             o_valid,
    output logic             o_eop,
    output logic [WF-1:0]    o_flow,
    input  logic             i_ready
);

    localparam int GW = (NI > 1) ? $clog2(NI) : 1;
    localparam logic [GW-1:0] LAST_RST = GW'(NI - 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t          r_state, w_state_next;
    logic [GW-1:0]   r_gnt, w_gnt_next;
    logic [GW-1:0]   r_last, w_last_next;

    logic [GW-1:0]   w_rr_sel;
    logic            w_rr_hit;
    int              w_rr_best;
    logic [GW-1:0]   w_sel;
    logic            w_has_sel;
    logic            w_sel_valid;
    logic            w_sel_eop;
    logic [WO-1:0]   w_sel_data;
    logic [WF-1:0]   w_sel_flow;
    logic            w_xfer;

    // Pick the valid input at the smallest rotational distance after the last winner.
    always_comb begin
        w_rr_sel  = '0;
        w_rr_hit  = 1'b0;
        w_rr_best = NI;
        for (int k = 0; k < NI; k++) begin
            if (i_valid[k] && (((k - int'(r_last) - 1 + 2 * NI) % NI) < w_rr_best)) begin
                w_rr_best = (k - int'(r_last) - 1 + 2 * NI) % NI;
                w_rr_sel  = GW'(k);
                w_rr_hit  = 1'b1;
            end
        end
    end

    assign w_has_sel = (r_state == ST_LOCKED) || w_rr_hit;
    assign w_sel     = (r_state == ST_LOCKED) ? r_gnt : w_rr_sel;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_eop   = 1'b0;
        w_sel_data  = '0;
        w_sel_flow  = '0;
        for (int k = 0; k < NI; k++) begin
            if (w_sel == GW'(k)) begin
                w_sel_valid = i_valid[k];
                w_sel_eop   = i_eop[k];
                w_sel_data  = i_data[k*WO +: WO];
                w_sel_flow  = i_flow[k*WF +: WF];
            end
        end
    end

    assign o_valid = w_has_sel && w_sel_valid;
    assign o_data  = o_valid ? w_sel_data : '0;
    assign o_flow  = o_valid ? w_sel_flow : '0;
    assign o_eop   = o_valid ? w_sel_eop  : 1'b0;
    assign w_xfer  = o_valid && i_ready;

    // While locked, ready stays asserted to the owner even across its valid bubbles.
    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_ready
            assign o_ready[gi] = w_has_sel && (w_sel == GW'(gi)) && i_ready
                                 && ((r_state == ST_LOCKED) || i_valid[gi]);
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_last_next  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (o_valid) begin
                    if (w_xfer && w_sel_eop) begin
                        w_last_next = w_sel;
                    end else begin
                        w_state_next = ST_LOCKED;
                        w_gnt_next   = w_sel;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_xfer && w_sel_eop) begin
                    w_state_next = ST_IDLE;
                    w_last_next  = r_gnt;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_last  <= LAST_RST;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_last  <= w_last_next;
        end
    end

endmodule

// File: tb/tb_ct_merge_arb.sv
// Directed bench for ct_merge_arb with three inputs; each beat checks valid/data/flow/eop/ready.
module tb_ct_merge_arb;

    localparam int NI = 3;
    localparam int WO = 8;
    localparam int WF = 4;

    logic             clk;
    logic             reset;
    logic [NI*WO-1:0] i_data;
    logic [NI-1:0]    i_valid;
    logic [NI-1:0]    i_eop;
    logic [NI*WF-1:0] i_flow;
    logic [NI-1:0]    o_ready;
    logic [WO-1:0]    o_data;
    logic             o_valid;
    logic             o_eop;
    logic [WF-1:0]    o_flow;
    logic             i_ready;

    int total = 0;
    int bad   = 0;

    ct_merge_arb #(.NI(NI), .WO(WO), .WF(WF)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_eop   (i_eop),
        .i_flow  (i_flow),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_eop   (o_eop),
        .o_flow  (o_flow),
        .i_ready (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int k, input logic v, input logic [7:0] d,
                          input logic [3:0] f, input logic e);
        i_valid[k]         = v;
        i_data[k*WO +: WO] = d;
        i_flow[k*WF +: WF] = f;
        i_eop[k]           = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one cycle's outputs mid-cycle, print it, then advance past the next edge.
    task automatic beat(input string tag, input logic v, input logic [7:0] d,
                        input logic [3:0] f, input logic e, input logic [2:0] rdy);
        #1;
        $display("[%0t] %s: valid=%b data=%h flow=%h eop=%b ready=%b",
                 $time, tag, o_valid, o_data, o_flow, o_eop, o_ready);
        chk({tag, ".valid"}, 32'(o_valid), 32'(v));
        chk({tag, ".data"},  32'(o_data),  32'(d));
        chk({tag, ".flow"},  32'(o_flow),  32'(f));
        chk({tag, ".eop"},   32'(o_eop),   32'(e));
        chk({tag, ".ready"}, 32'(o_ready), 32'(rdy));
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        i_data  = '0;
        i_valid = '0;
        i_eop   = '0;
        i_flow  = '0;
        i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state, nothing valid
        beat("rst_idle", 1'b0, 8'h00, 4'h0, 1'b0, 3'b000);

        // Single-beat packets on inputs 0 and 2
        i_ready = 1'b1;
        set_in(0, 1'b1, 8'h10, 4'h1, 1'b1);
        set_in(2, 1'b1, 8'h30, 4'h3, 1'b1);
        beat("rr_c0", 1'b1, 8'h10, 4'h1, 1'b1, 3'b001);
        beat("rr_c1", 1'b1, 8'h30, 4'h3, 1'b1, 3'b100);
        beat("rr_c2", 1'b1, 8'h10, 4'h1, 1'b1, 3'b001);
        set_in(0, 1'b0, 8'h00, 4'h0, 1'b0);
        set_in(2, 1'b0, 8'h00, 4'h0, 1'b0);
        beat("rr_idle", 1'b0, 8'h00, 4'h0, 1'b0, 3'b000);

        // Three-beat packet on input 1 while input 0 waits
        set_in(0, 1'b1, 8'h11, 4'h1, 1'b1);
        set_in(1, 1'b1, 8'hA1, 4'h2, 1'b0);
        beat("pkt_b0", 1'b1, 8'hA1, 4'h2, 1'b0, 3'b010);
        set_in(1, 1'b1, 8'hA2, 4'h2, 1'b0);
        beat("pkt_b1", 1'b1, 8'hA2, 4'h2, 1'b0, 3'b010);
        set_in(1, 1'b1, 8'hA3, 4'h2, 1'b1);
        beat("pkt_b2", 1'b1, 8'hA3, 4'h2, 1'b1, 3'b010);
        set_in(1, 1'b0, 8'h00, 4'h0, 1'b0);
        beat("pkt_next", 1'b1, 8'h11, 4'h1, 1'b1, 3'b001);
        set_in(0, 1'b0, 8'h00, 4'h0, 1'b0);

        // Stalled beat on input 2 must not be re-arbitrated
        i_ready = 1'b0;
        set_in(2, 1'b1, 8'h55, 4'h7, 1'b1);
        beat("stall_c0", 1'b1, 8'h55, 4'h7, 1'b1, 3'b000);
        beat("stall_c1", 1'b1, 8'h55, 4'h7, 1'b1, 3'b000);
        set_in(0, 1'b1, 8'h01, 4'h3, 1'b1);
        beat("stall_c2", 1'b1, 8'h55, 4'h7, 1'b1, 3'b000);
        i_ready = 1'b1;
        beat("stall_go", 1'b1, 8'h55, 4'h7, 1'b1, 3'b100);
        set_in(2, 1'b0, 8'h00, 4'h0, 1'b0);
        beat("stall_next", 1'b1, 8'h01, 4'h3, 1'b1, 3'b001);
        set_in(0, 1'b0, 8'h00, 4'h0, 1'b0);

        // Valid bubble inside a locked packet on input 1
        set_in(1, 1'b1, 8'hB1, 4'h5, 1'b0);
        set_in(2, 1'b1, 8'h22, 4'h6, 1'b1);
        beat("bub_b0", 1'b1, 8'hB1, 4'h5, 1'b0, 3'b010);
        set_in(1, 1'b0, 8'h00, 4'h0, 1'b0);
        beat("bub_gap0", 1'b0, 8'h00, 4'h0, 1'b0, 3'b010);
        beat("bub_gap1", 1'b0, 8'h00, 4'h0, 1'b0, 3'b010);
        set_in(1, 1'b1, 8'hB2, 4'h5, 1'b1);
        beat("bub_b1", 1'b1, 8'hB2, 4'h5, 1'b1, 3'b010);
        set_in(1, 1'b0, 8'h00, 4'h0, 1'b0);
        beat("bub_next", 1'b1, 8'h22, 4'h6, 1'b1, 3'b100);
        set_in(2, 1'b0, 8'h00, 4'h0, 1'b0);

        // Asynchronous reset while locked on input 2
        i_ready = 1'b0;
        set_in(2, 1'b1, 8'h66, 4'h9, 1'b0);
        beat("lock2", 1'b1, 8'h66, 4'h9, 1'b0, 3'b000);
        set_in(0, 1'b1, 8'h0A, 4'hA, 1'b1);
        beat("lock2_hold", 1'b1, 8'h66, 4'h9, 1'b0, 3'b000);
        reset   = 1'b1;
        i_ready = 1'b1;
        set_in(2, 1'b1, 8'h66, 4'h9, 1'b1);
        #1;
        chk("arst_data", 32'(o_data), 32'h0A);
        chk("arst_ready", 32'(o_ready), 32'b001);
        tick();
        reset = 1'b0;
        beat("post_rst0", 1'b1, 8'h0A, 4'hA, 1'b1, 3'b001);
        set_in(0, 1'b0, 8'h00, 4'h0, 1'b0);
        beat("post_rst1", 1'b1, 8'h66, 4'h9, 1'b1, 3'b100);
        set_in(2, 1'b0, 8'h00, 4'h0, 1'b0);

        // All inputs continuously valid: strict rotation 0,1,2,0,1,2
        set_in(0, 1'b1, 8'hC0, 4'h0, 1'b1);
        set_in(1, 1'b1, 8'hC1, 4'h1, 1'b1);
        set_in(2, 1'b1, 8'hC2, 4'h2, 1'b1);
        for (int r = 0; r < 2; r++) begin
            beat("rot_in0", 1'b1, 8'hC0, 4'h0, 1'b1, 3'b001);
            beat("rot_in1", 1'b1, 8'hC1, 4'h1, 1'b1, 3'b010);
            beat("rot_in2", 1'b1, 8'hC2, 4'h2, 1'b1, 3'b100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ct_merge_arb.md
# ct_merge_arb

Round-robin, packet-locking merge arbiter sharing one flow-tagged ready/valid output among NI input streams; the converging counterpart to split nodes in the interconnect fabric. Selects one requesting input per packet, holds the grant from first beat through the end-of-packet beat (or while a presented beat is stalled), and forwards data, flow_id and eop unchanged. Zero-latency combinational datapath; only arbitration state is registered.

## Interface
- NI, 2, number of inputs (≥1)
- WO, 8, data width per stream
- WF, 4, flow_id width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- i_data  in  NI*WO  input data, input k at [k*WO +: WO]
- i_valid  in  NI  per-input valid
- i_eop  in  NI  per-input end-of-packet marker
- i_flow  in  NI*WF  per-input flow_id, input k at [k*WF +: WF]
- o_ready  out  NI  per-input ready (backpressure to sources)
- o_data  out  WO  merged data
- o_valid  out  1  merged valid
- o_eop  out  1  merged end-of-packet
- o_flow  out  WF  merged flow_id
- i_ready  in  1  downstream ready

## Operation
- Registers: state {IDLE, LOCKED}, gnt (index, $clog2(NI) bits, min 1), last (index of last completed winner).
- Reset: state=IDLE, gnt=0, last=NI-1 (input 0 highest priority first).
- IDLE: sel = first k with i_valid[k]=1 searching last+1, last+2, … modulo NI; if none, no selection.
- LOCKED: sel = gnt, regardless of other requests.
- o_valid = selection exists && i_valid[sel]; o_data/o_flow/o_eop = input sel's fields when o_valid=1, else all-zero.
- o_ready[k] = (k==sel) && i_ready && (state==LOCKED || i_valid[k]); all other bits 0.
- Transfer = o_valid && i_ready.
- Transitions (posedge):
  - IDLE, o_valid=1, transfer with eop → stay IDLE, last←sel.
  - IDLE, o_valid=1, otherwise (no transfer, or non-eop transfer) → LOCKED, gnt←sel.
  - LOCKED, transfer with eop → IDLE, last←gnt.
  - LOCKED, anything else (including i_valid[gnt]=0 bubble) → stay LOCKED.
- A stalled beat is never re-arbitrated: once o_valid rises for an input, data/flow/eop shown stay from that input until accepted.
- NI=1: sel always 0; state machine still tracks eop (no functional effect).
- Fairness: each requester waits at most NI-1 packets.

## Timing
- Combinational paths: i_valid/i_data/i_flow/i_eop → o_*; i_ready → o_ready. No registered output stage; latency 0 cycles.
- State, gnt, last update only on rising clk; change visible in the next cycle's selection.
- After reset deassertion, with no inputs valid: o_valid=0, o_data=0, o_flow=0, o_eop=0, o_ready=0.
- Reset asserted mid-packet: immediately IDLE/gnt=0/last=NI-1; in-flight packet truncated (upstream's responsibility); next arbitration starts at input 0.
- Simultaneous eop completion and new requests: new winner chosen in the cycle after the eop beat (one beat per cycle, no idle bubble when others are waiting).
- Sources must hold valid/data stable until o_ready; downstream may drop i_ready anytime.

## Test plan
- NI=3, reset, then i_valid=3'b101 with single-beat eop packets data 0x10 (in0)/0x30 (in2), i_ready=1 → cycle0 o_data=0x10 o_ready=3'b001; cycle1 o_data=0x30 o_ready=3'b100; cycle2 in0 again.
- Input 1 sends 3-beat packet 0xA1,0xA2,0xA3 (eop on 0xA3) while input 0 valid throughout → o_data 0xA1,0xA2,0xA3 consecutively with o_ready=3'b010; input 0 granted the following cycle.
- i_ready=0 with input 2 valid (data 0x55, flow 4'h7, eop=1), input 0 raises valid 2 cycles later → o_data=0x55/o_flow=7 stable, o_ready=0; after i_ready=1 for one cycle 0x55 transfers, then input 0 selected.
- Input 1 mid-packet drops i_valid for 2 cycles while input 2 valid → o_valid=0, o_ready[2]=0 both cycles; input 1 resumes and finishes before input 2 is granted.
- Reset pulsed during LOCKED on input 2, inputs 0 and 2 valid afterward → first granted input is 0.
- All 3 inputs continuously valid single-beat, i_ready=1 → grant sequence 0,1,2,0,1,2; each o_ready[k] high exactly 1 cycle in 3.
